interrupt_register: RTL and testbench
=====================================

INTERRUPT_REGISTER -- requirements
Module: interrupt_register

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 activintreg  in  1  set strobe from the interrupt unit; qualifies the three source lines.
REQ-005 irqsucrec  in  1  with activintreg=1: successful-receive event, source 0.
REQ-006 irqsuctra  in  1  with activintreg=1: successful-transmit event, source 1.
REQ-007 irqstatus  in  1  with activintreg=1: status-change event, source 2.
REQ-008 wr  in  1  CPU write strobe, single cycle.
REQ-009 rd  in  1  CPU read strobe, single cycle.
REQ-010 addr  in  1  register select: 0 = IER/ISR, 1 = overrun counters.
REQ-011 wdata  in  16  CPU write data.
REQ-012 rdata  out  16  registered CPU read data.
REQ-013 ienable  out  3  interrupt enable bits [2:0], indexed by source number.
REQ-014 irqstd  out  3  pending interrupt bits [2:0], indexed by source number, fed back to the interrupt unit.

Function
REQ-015 Register at addr 0 SHALL map: [2:0] ienable (RW), [6:4] irqstd (write-1-to-clear), [10:8] ovr flags (write-1-to-clear); all other bits read 0 and ignore writes.
REQ-016 Register at addr 1 SHALL map: [3:0] cnt0, [7:4] cnt1, [11:8] cnt2 (read-only); a write with wdata[15]=1 clears all three counters; bits [15:12] read 0.
REQ-017 Set event for source n: activintreg=1 and that source's line=1 at a rising edge; irqstd[n] SHALL be 1 after that edge.
REQ-018 When activintreg=0, the three source lines SHALL be ignored.
REQ-019 Multiple source lines high in one cycle SHALL each be honoured independently.
REQ-020 A set event for source n while irqstd[n] is already 1 SHALL set ovr[n] and increment cnt[n] by 1.
REQ-021 cnt[n] SHALL be 4 bits and saturate at 15, never wrapping to 0.
REQ-022 A CPU write to addr 0 with wdata[4+n]=1 SHALL clear irqstd[n]; writing 0 leaves the bit unchanged.
REQ-023 A CPU write to addr 0 with wdata[8+n]=1 SHALL clear ovr[n]; writing 0 leaves the bit unchanged.
REQ-024 In the same cycle as a clear, a set event on the same source SHALL win: the bit ends at 1, and no overrun is counted.
REQ-025 In the same cycle as a counter clear, an overrun on the same source SHALL win: the counter ends at 1.
REQ-026 A write of ienable[n]=0 SHALL also clear irqstd[n] and ovr[n] at the same edge.
REQ-027 If a set event on source n coincides with that write, the disable SHALL win.
REQ-028 rd=1 SHALL load rdata at the next edge with the selected register's pre-edge contents; latency is 1 cycle.
REQ-029 rdata SHALL hold its value while rd=0.
REQ-030 wr and rd asserted in the same cycle SHALL return pre-write values on rdata, and the write SHALL take effect.
REQ-031 Read accesses SHALL have no side effects on any state.
REQ-032 ienable and irqstd outputs SHALL be driven directly from state registers with no combinational path from inputs.
REQ-033 Write-access FSM states: IDLE, then CAPTURE when wr=1, then IDLE.
REQ-034 Data is latched in CAPTURE, and the register update SHALL occur at the edge leaving CAPTURE, 2 edges after wr.
REQ-035 A wr in CAPTURE SHALL be queued in a single-entry buffer and applied next; a third back-to-back wr while the buffer is full SHALL be dropped, setting a sticky wr_drop bit read at addr 0 [15], which is write-1-to-clear.

Reset
REQ-036 On reset=0, ienable, irqstd, ovr, all counters, wr_drop, rdata and the write buffer SHALL go to 0, and the FSM SHALL go to IDLE, asynchronously.
REQ-037 A set event during reset SHALL be lost; after release, the first edge with reset=1 SHALL process inputs normally.
REQ-038 A write pending in CAPTURE or the buffer when reset is asserted SHALL be discarded.

Verification
REQ-039 Write 0x0007 to addr 0, then pulse activintreg+irqsucrec -> irqstd=3'b001; a read of addr 0 returns 0x0017.
REQ-040 With irqstd[1]=1, issue 3 more transmit events -> ovr[1]=1 and cnt1=3; 20 events -> cnt1=15 (saturated).
REQ-041 Write 0x0010 to addr 0 in the same cycle as a receive set event -> irqstd[0] remains 1.
REQ-042 Write 0x0003 to addr 0 with irqstd=3'b111 -> irqstd=3'b011 and ovr[2]=0; subsequent status events are ignored.
REQ-043 Issue 3 back-to-back wr cycles -> the first two are applied in order, the third is dropped, and addr 0 reads bit15=1.
REQ-044 Assert reset mid-CAPTURE -> all outputs are 0 and no write is applied after release.

Source files
------------

// File: rtl/interrupt_register.sv
// ============================================================================
// interrupt_register
// ----------------------------------------------------------------------------
// Purpose:
//   Holds the interrupt enable, pending and overrun state for three interrupt
//   sources (0 = receive, 1 = transmit, 2 = status). It also keeps a 4-bit
//   saturating overrun counter per source. The CPU reaches it through a small
//   two-register window:
//     addr 0 : [2:0]  ienable (RW)
//              [6:4]  irqstd  (W1C)
//              [10:8] ovr     (W1C)
//              [15]   wr_drop (W1C, sticky)
//     addr 1 : [3:0] cnt0, [7:4] cnt1, [11:8] cnt2 (RO)
//              writing wdata[15]=1 clears all counters
//   CPU writes pass through a two-state write FSM (IDLE -> CAPTURE -> IDLE).
//   The register update happens on the edge that leaves CAPTURE. A single-entry
//   buffer absorbs one write that arrives while CAPTURE is busy. Any further
//   write that arrives while the buffer is full is dropped, and that drop is
//   recorded in wr_drop.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_activintreg  set strobe qualifying the three source lines
//   i_irqsucrec    source 0 event line (successful receive)
//   i_irqsuctra    source 1 event line (successful transmit)
//   i_irqstatus    source 2 event line (status change)
//   i_wr           CPU write strobe (single cycle)
//   i_rd           CPU read strobe (single cycle)
//   i_addr         register select
//   i_wdata[15:0]  CPU write data
//   o_rdata[15:0]  registered read data, one cycle after i_rd
//   o_ienable[2:0] interrupt enables, indexed by source
//   o_irqstd[2:0]  pending interrupts, indexed by source
// ============================================================================
module interrupt_register (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_activintreg,
    input  logic        i_irqsucrec,
    input  logic        i_irqsuctra,
    input  logic        i_irqstatus,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic        i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic [2:0]  o_ienable,
    output logic [2:0]  o_irqstd
);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Overrun counters stick at 15 rather than wrapping to 0.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } wr_state_t;

    wr_state_t   r_state;
    logic        r_cap_addr;
    logic [15:0] r_cap_data;
    logic        r_buf_vld;
    logic        r_buf_addr;
    logic [15:0] r_buf_data;
    logic        r_wr_drop;

    logic [2:0]  r_ien;
    logic [2:0]  r_irq;
    logic [2:0]  r_ovr;
    logic [3:0]  r_cnt [3];
    logic [15:0] r_rdata;

    // ------------------------------------------------------------------------
    // Combinational next-state for the register bank
    // ------------------------------------------------------------------------
    logic        w_apply;
    logic        w_wr0;
    logic        w_wr1;
    logic [2:0]  w_set;
    logic        w_drop;
    logic        w_drop_clr;
    logic [2:0]  w_ien_nxt;
    logic [2:0]  w_irq_nxt;
    logic [2:0]  w_ovr_nxt;
    logic [3:0]  w_cnt_nxt [3];
    logic [15:0] w_reg0;
    logic [15:0] w_reg1;

    // The captured write is committed on the edge that leaves CAPTURE.
    assign w_apply = (r_state == S_CAPTURE);
    assign w_wr0   = w_apply && (r_cap_addr == 1'b0);
    assign w_wr1   = w_apply && (r_cap_addr == 1'b1);

    // Source events count only while that source is enabled. A disabled
    // source never raises a pending bit.
    assign w_set = {i_irqstatus, i_irqsuctra, i_irqsucrec}
                   & {3{i_activintreg}} & r_ien;

    // A write that arrives while the buffer is full has nowhere to go.
    assign w_drop     = i_wr && r_buf_vld;
    assign w_drop_clr = w_wr0 && r_cap_data[15];

    always_comb begin
        w_ien_nxt = r_ien;
        w_irq_nxt = r_irq;
        w_ovr_nxt = r_ovr;
        for (int n = 0; n < 3; n++) begin
            w_cnt_nxt[n] = r_cnt[n];
        end

        if (w_wr0) begin
            w_ien_nxt = r_cap_data[2:0];
        end

        for (int n = 0; n < 3; n++) begin
            logic dis;
            logic clr_irq;
            logic clr_ovr;
            logic clr_cnt;
            logic ovrrun;

            dis     = w_wr0 && !r_cap_data[n];
            clr_irq = w_wr0 && r_cap_data[4+n];
            clr_ovr = w_wr0 && r_cap_data[8+n];
            clr_cnt = w_wr1 && r_cap_data[15];
            // A set that coincides with a clear of the same pending bit
            // re-arms the bit without counting as an overrun.
            ovrrun  = w_set[n] && r_irq[n] && !clr_irq && !dis;

            // Pending bit priority: disable > set > clear.
            if (dis) begin
                w_irq_nxt[n] = 1'b0;
            end else if (w_set[n]) begin
                w_irq_nxt[n] = 1'b1;
            end else if (clr_irq) begin
                w_irq_nxt[n] = 1'b0;
            end

            // Overrun flag priority: disable > overrun > clear.
            if (dis) begin
                w_ovr_nxt[n] = 1'b0;
            end else if (ovrrun) begin
                w_ovr_nxt[n] = 1'b1;
            end else if (clr_ovr) begin
                w_ovr_nxt[n] = 1'b0;
            end

            // If a counter clear and an overrun land on the same edge, the
            // counter restarts at 1.
            if (ovrrun) begin
                w_cnt_nxt[n] = clr_cnt ? 4'd1 : sat_inc(r_cnt[n]);
            end else if (clr_cnt) begin
                w_cnt_nxt[n] = 4'd0;
            end
        end
    end

    // Read views of the two registers. Unused bits read as 0.
    assign w_reg0 = {r_wr_drop, 4'b0000, r_ovr, 1'b0, r_irq, 1'b0, r_ien};
    assign w_reg1 = {4'b0000, r_cnt[2], r_cnt[1], r_cnt[0]};

    // ------------------------------------------------------------------------
    // Write-access FSM with single-entry buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cap_addr <= 1'b0;
            r_cap_data <= 16'h0000;
            r_buf_vld  <= 1'b0;
            r_buf_addr <= 1'b0;
            r_buf_data <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_buf_vld) begin
                        // Drain the queued write first. A concurrent wr is
                        // dropped because the buffer is still full.
                        r_cap_addr <= r_buf_addr;
                        r_cap_data <= r_buf_data;
                        r_buf_vld  <= 1'b0;
                        r_state    <= S_CAPTURE;
                    end else if (i_wr) begin
                        r_cap_addr <= i_addr;
                        r_cap_data <= i_wdata;
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                    if (i_wr && !r_buf_vld) begin
                        r_buf_addr <= i_addr;
                        r_buf_data <= i_wdata;
                        r_buf_vld  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register bank and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ien     <= 3'b000;
            r_irq     <= 3'b000;
            r_ovr     <= 3'b000;
            r_wr_drop <= 1'b0;
            r_rdata   <= 16'h0000;
            for (int n = 0; n < 3; n++) begin
                r_cnt[n] <= 4'd0;
            end
        end else begin
            r_ien <= w_ien_nxt;
            r_irq <= w_irq_nxt;
            r_ovr <= w_ovr_nxt;
            for (int n = 0; n < 3; n++) begin
                r_cnt[n] <= w_cnt_nxt[n];
            end
            // A new drop beats a clear on the same edge, so no event is lost.
            r_wr_drop <= w_drop | (r_wr_drop & ~w_drop_clr);
            // The read returns the state from before this edge, so a write
            // committing on the same edge is not yet visible.
            if (i_rd) begin
                r_rdata <= i_addr ? w_reg1 : w_reg0;
            end
        end
    end

    assign o_rdata   = r_rdata;
    assign o_ienable = r_ien;
    assign o_irqstd  = r_irq;

endmodule

// File: tb/tb_interrupt_register.sv
module tb_interrupt_register;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_activintreg = 1'b0;
    logic        i_irqsucrec = 1'b0;
    logic        i_irqsuctra = 1'b0;
    logic        i_irqstatus = 1'b0;
    logic        i_wr = 1'b0;
    logic        i_rd = 1'b0;
    logic        i_addr = 1'b0;
    logic [15:0] i_wdata = 16'h0000;
    logic [15:0] o_rdata;
    logic [2:0]  o_ienable;
    logic [2:0]  o_irqstd;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_register dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_activintreg (i_activintreg),
        .i_irqsucrec   (i_irqsucrec),
        .i_irqsuctra   (i_irqsuctra),
        .i_irqstatus   (i_irqstatus),
        .i_wr          (i_wr),
        .i_rd          (i_rd),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ienable     (o_ienable),
        .o_irqstd      (o_irqstd)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_lines(input logic act, input logic [2:0] src);
        i_activintreg = act;
        i_irqsucrec   = src[0];
        i_irqsuctra   = src[1];
        i_irqstatus   = src[2];
    endtask

    task automatic pulse_evt(input logic [2:0] src);
        set_lines(1'b1, src);
        tick();
        set_lines(1'b0, 3'b000);
    endtask

    // Complete write: the wr edge, then the edge that commits the write.
    task automatic do_wr(input logic a, input logic [15:0] d);
        i_wr = 1'b1; i_addr = a; i_wdata = d;
        tick();
        i_wr = 1'b0;
        tick();
    endtask

    task automatic do_rd(input logic a, output logic [15:0] d);
        i_rd = 1'b1; i_addr = a;
        tick();
        i_rd = 1'b0;
        d = o_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        tick(); tick();
        n_checks++; if (o_ienable !== 3'b000) begin n_fail++; $display("FAIL rst_ien: got %b exp 000", o_ienable); end
        n_checks++; if (o_irqstd !== 3'b000) begin n_fail++; $display("FAIL rst_irq: got %b exp 000", o_irqstd); end
        n_checks++; if (o_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0000", o_rdata); end
        i_rst_n = 1'b1;
        tick();
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_reg0: got %h exp 0000", d); end
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_reg1: got %h exp 0000", d); end
    endtask

    task automatic test_set_and_read();
        logic [15:0] d;
        do_wr(1'b0, 16'h0007);
        n_checks++; if (o_ienable !== 3'b111) begin n_fail++; $display("FAIL ien_write: got %b exp 111", o_ienable); end
        n_checks++; if (o_irqstd !== 3'b000) begin n_fail++; $display("FAIL irq_idle: got %b exp 000", o_irqstd); end
        pulse_evt(3'b001);
        n_checks++; if (o_irqstd !== 3'b001) begin n_fail++; $display("FAIL irq_set0: got %b exp 001", o_irqstd); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0017) begin n_fail++; $display("FAIL read_0017: got %h exp 0017", d); end
        i_addr = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (o_rdata !== 16'h0017) begin n_fail++; $display("FAIL rdata_hold: got %h exp 0017", o_rdata); end
    endtask

    task automatic test_inactive();
        set_lines(1'b0, 3'b111);
        tick();
        set_lines(1'b0, 3'b000);
        n_checks++; if (o_irqstd !== 3'b001) begin n_fail++; $display("FAIL ignore_inactive: got %b exp 001", o_irqstd); end
        pulse_evt(3'b000);
        n_checks++; if (o_irqstd !== 3'b001) begin n_fail++; $display("FAIL no_lines: got %b exp 001", o_irqstd); end
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        pulse_evt(3'b010);
        n_checks++; if (o_irqstd !== 3'b011) begin n_fail++; $display("FAIL irq_set1: got %b exp 011", o_irqstd); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0037) begin n_fail++; $display("FAIL no_ovr_yet: got %h exp 0037", d); end
        for (int i = 0; i < 3; i++) pulse_evt(3'b010);
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0237) begin n_fail++; $display("FAIL ovr1_set: got %h exp 0237", d); end
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h0030) begin n_fail++; $display("FAIL cnt1_3: got %h exp 0030", d); end
        for (int i = 0; i < 20; i++) pulse_evt(3'b010);
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h00F0) begin n_fail++; $display("FAIL cnt1_sat: got %h exp 00f0", d); end
    endtask

    task automatic test_multi();
        logic [15:0] d;
        pulse_evt(3'b101);
        n_checks++; if (o_irqstd !== 3'b111) begin n_fail++; $display("FAIL multi_irq: got %b exp 111", o_irqstd); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0377) begin n_fail++; $display("FAIL multi_reg0: got %h exp 0377", d); end
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h00F1) begin n_fail++; $display("FAIL multi_reg1: got %h exp 00f1", d); end
    endtask

    task automatic test_set_beats_clear();
        logic [15:0] d;
        // Enables stay set so only the clear-versus-set race on source 0 is exercised.
        i_wr = 1'b1; i_addr = 1'b0; i_wdata = 16'h0017;
        tick();
        i_wr = 1'b0;
        set_lines(1'b1, 3'b001);
        tick();
        set_lines(1'b0, 3'b000);
        n_checks++; if (o_irqstd !== 3'b111) begin n_fail++; $display("FAIL set_wins: got %b exp 111", o_irqstd); end
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h00F1) begin n_fail++; $display("FAIL no_ovr_count: got %h exp 00f1", d); end
        do_wr(1'b0, 16'h0027);
        n_checks++; if (o_irqstd !== 3'b101) begin n_fail++; $display("FAIL clear_irq1: got %b exp 101", o_irqstd); end
    endtask

    task automatic test_clear_ovr_cnt();
        logic [15:0] d;
        do_wr(1'b0, 16'h0307);
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0057) begin n_fail++; $display("FAIL ovr_clear: got %h exp 0057", d); end
        i_wr = 1'b1; i_addr = 1'b1; i_wdata = 16'h8000;
        tick();
        i_wr = 1'b0;
        set_lines(1'b1, 3'b001);
        tick();
        set_lines(1'b0, 3'b000);
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL cnt_clr_vs_ovr: got %h exp 0001", d); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0157) begin n_fail++; $display("FAIL ovr0_reset: got %h exp 0157", d); end
    endtask

    task automatic test_disable();
        logic [15:0] d;
        pulse_evt(3'b010);
        pulse_evt(3'b100);
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0577) begin n_fail++; $display("FAIL pre_disable: got %h exp 0577", d); end
        i_wr = 1'b1; i_addr = 1'b0; i_wdata = 16'h0003;
        tick();
        i_wr = 1'b0;
        set_lines(1'b1, 3'b100);
        tick();
        set_lines(1'b0, 3'b000);
        n_checks++; if (o_irqstd !== 3'b011) begin n_fail++; $display("FAIL disable_wins: got %b exp 011", o_irqstd); end
        pulse_evt(3'b100);
        n_checks++; if (o_irqstd !== 3'b011) begin n_fail++; $display("FAIL disabled_ignored: got %b exp 011", o_irqstd); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0133) begin n_fail++; $display("FAIL post_disable: got %h exp 0133", d); end
        do_rd(1'b1, d);
        n_checks++; if (d !== 16'h0101) begin n_fail++; $display("FAIL cnt_after_dis: got %h exp 0101", d); end
    endtask

    task automatic test_rd_wr_same();
        i_wr = 1'b1; i_rd = 1'b1; i_addr = 1'b0; i_wdata = 16'h0007;
        tick();
        i_wr = 1'b0; i_rd = 1'b0;
        n_checks++; if (o_rdata !== 16'h0133) begin n_fail++; $display("FAIL rdwr_prewrite: got %h exp 0133", o_rdata); end
        n_checks++; if (o_ienable !== 3'b011) begin n_fail++; $display("FAIL wr_latency: got %b exp 011", o_ienable); end
        tick();
        n_checks++; if (o_ienable !== 3'b111) begin n_fail++; $display("FAIL rdwr_applied: got %b exp 111", o_ienable); end
        n_checks++; if (o_rdata !== 16'h0133) begin n_fail++; $display("FAIL rdwr_hold: got %h exp 0133", o_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        i_wr = 1'b1; i_addr = 1'b0; i_wdata = 16'h0001;
        tick();
        i_wdata = 16'h0003;
        tick();
        n_checks++; if (o_ienable !== 3'b001) begin n_fail++; $display("FAIL b2b_first: got %b exp 001", o_ienable); end
        n_checks++; if (o_irqstd !== 3'b001) begin n_fail++; $display("FAIL b2b_irq: got %b exp 001", o_irqstd); end
        i_wdata = 16'h0007;
        tick();
        i_wr = 1'b0;
        tick();
        n_checks++; if (o_ienable !== 3'b011) begin n_fail++; $display("FAIL b2b_second: got %b exp 011", o_ienable); end
        tick(); tick();
        n_checks++; if (o_ienable !== 3'b011) begin n_fail++; $display("FAIL b2b_third_dropped: got %b exp 011", o_ienable); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h8113) begin n_fail++; $display("FAIL wr_drop_flag: got %h exp 8113", d); end
        do_wr(1'b0, 16'h8003);
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0113) begin n_fail++; $display("FAIL wr_drop_clear: got %h exp 0113", d); end
    endtask

    task automatic test_reset_mid_capture();
        logic [15:0] d;
        i_wr = 1'b1; i_addr = 1'b0; i_wdata = 16'h0007;
        tick();
        i_wr = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_ienable !== 3'b000) begin n_fail++; $display("FAIL async_rst_ien: got %b exp 000", o_ienable); end
        n_checks++; if (o_irqstd !== 3'b000) begin n_fail++; $display("FAIL async_rst_irq: got %b exp 000", o_irqstd); end
        n_checks++; if (o_rdata !== 16'h0000) begin n_fail++; $display("FAIL async_rst_rdata: got %h exp 0000", o_rdata); end
        set_lines(1'b1, 3'b111);
        tick();
        set_lines(1'b0, 3'b000);
        i_rst_n = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (o_ienable !== 3'b000) begin n_fail++; $display("FAIL capture_discarded: got %b exp 000", o_ienable); end
        n_checks++; if (o_irqstd !== 3'b000) begin n_fail++; $display("FAIL event_in_reset_lost: got %b exp 000", o_irqstd); end
        do_rd(1'b0, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL post_rst_reg0: got %h exp 0000", d); end
        do_wr(1'b0, 16'h0004);
        pulse_evt(3'b100);
        n_checks++; if (o_irqstd !== 3'b100) begin n_fail++; $display("FAIL post_rst_event: got %b exp 100", o_irqstd); end
    endtask

    initial begin
        test_reset();
        test_set_and_read();
        test_inactive();
        test_overrun();
        test_multi();
        test_set_beats_clear();
        test_clear_ovr_cnt();
        test_disable();
        test_rd_wr_same();
        test_back_to_back();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
